// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: major opcodes and the instruction-format enum.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational format classifier and immediate generator for 32-bit base instructions.
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  fmt_e        fmt_s;
  logic        illegal_s;
  logic [31:0] imm32_s;

  // Classify the format from the major opcode; compressed/reserved low bits are illegal.
  always_comb begin
    fmt_s     = FMT_NONE;
    illegal_s = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_LUI, OP_AUIPC: begin
          fmt_s     = FMT_U;
          illegal_s = 1'b0;
        end
        OP_JAL: begin
          fmt_s     = FMT_J;
          illegal_s = 1'b0;
        end
        OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
          fmt_s     = FMT_I;
          illegal_s = 1'b0;
        end
        OP_BRANCH: begin
          fmt_s     = FMT_B;
          illegal_s = 1'b0;
        end
        OP_STORE: begin
          fmt_s     = FMT_S;
          illegal_s = 1'b0;
        end
        OP_REG: begin
          fmt_s     = FMT_R;
          illegal_s = 1'b0;
        end
        default: begin
          fmt_s     = FMT_NONE;
          illegal_s = 1'b1;
        end
      endcase
    end else begin
      fmt_s     = FMT_NONE;
      illegal_s = 1'b1;
    end
  end

  // Assemble the 32-bit sign-extended immediate for the chosen format.
  always_comb begin
    imm32_s = 32'd0;
    case (fmt_s)
      FMT_I: imm32_s = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32_s = {instr[31:12], 12'd0};
      FMT_J: imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign fmt     = fmt_s;
  assign illegal = illegal_s;
  // Bit 31 of every immediate above already equals instr[31], so widening by sign is sext.
  assign imm     = XLEN'($signed(imm32_s));

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered decode stage: one-entry valid/ready pipeline register holding the decoded
// instruction, with flush and saturating legal/illegal consume counters.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output fmt_e             fmt,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  fmt_e             dec_fmt_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic             dec_illegal_s;
  logic             accept_s;
  logic             consume_s;

  logic [31:0]      instr_r;
  fmt_e             fmt_r;
  logic [XLEN-1:0]  imm_r;
  logic             illegal_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] dec_count_r;
  logic [CNT_W-1:0] ill_count_r;

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (instr),
    .fmt     (dec_fmt_s),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready && !flush;
  assign consume_s = out_valid_r && out_ready;

  // Payload register: loads only on accept, so a stalled entry stays bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r   <= 32'd0;
      fmt_r     <= FMT_NONE;
      imm_r     <= {XLEN{1'b0}};
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      instr_r   <= instr;
      fmt_r     <= dec_fmt_s;
      imm_r     <= dec_imm_s;
      illegal_r <= dec_illegal_s;
    end else begin
      instr_r   <= instr_r;
      fmt_r     <= fmt_r;
      imm_r     <= imm_r;
      illegal_r <= illegal_r;
    end
  end

  // Valid flag: accept wins; otherwise a consume or a flush empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
    end else if (consume_s || flush) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating statistics: a consume during flush still counts since execute took it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count_r <= {CNT_W{1'b0}};
      ill_count_r <= {CNT_W{1'b0}};
    end else if (consume_s) begin
      if (illegal_r) begin
        if (ill_count_r != {CNT_W{1'b1}}) begin
          ill_count_r <= ill_count_r + CNT_W'(1);
        end else begin
          ill_count_r <= ill_count_r;
        end
      end else begin
        if (dec_count_r != {CNT_W{1'b1}}) begin
          dec_count_r <= dec_count_r + CNT_W'(1);
        end else begin
          dec_count_r <= dec_count_r;
        end
      end
    end else begin
      dec_count_r <= dec_count_r;
      ill_count_r <= ill_count_r;
    end
  end

  assign out_valid = out_valid_r;
  assign opcode    = instr_r[6:0];
  assign funct3    = instr_r[14:12];
  assign funct7    = instr_r[31:25];
  assign rs1       = instr_r[19:15];
  assign rs2       = instr_r[24:20];
  assign rd        = instr_r[11:7];
  assign fmt       = fmt_r;
  assign imm       = imm_r;
  assign illegal   = illegal_r;
  assign dec_count = dec_count_r;
  assign ill_count = ill_count_r;

endmodule
